// File: rtl/slc3_mem_sequencer_pkg.sv
// Shared types and constants for the SLC-3 memory sequencer.
package slc3_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    HOLD,
    DONE,
    RELEASE
  } state_t;

  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
  localparam int          CNT_W           = 4;

endpackage

// File: rtl/slc3_mem_sequencer_if.sv
// Controller-side request/ready handshake between the SLC-3 controller and the memory sequencer.
interface slc3_mem_sequencer_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] MAR;
  logic [15:0] MDR_out;
  logic        R;
  logic [15:0] rd_data;

  modport master (output mem_req, mem_we, MAR, MDR_out, input R, rd_data);
  modport slave  (input mem_req, mem_we, MAR, MDR_out, output R, rd_data);
endinterface

// File: rtl/slc3_mem_sequencer_data_tristate.sv
// Bidirectional SRAM data pad: drives the registered write word or floats, and returns the bus value.
module slc3_data_tristate (
  input  logic        drive_en,
  input  logic [15:0] out_data,
  output logic [15:0] in_data,
  inout  wire  [15:0] Data
);

  assign Data    = drive_en ? out_data : {16{1'bz}};
  assign in_data = Data;

endmodule

// File: rtl/slc3_mem_sequencer.sv
// SRAM strobe sequencer with wait states and memory-mapped switch/hex I/O for the SLC-3.
//
// state   | meaning
// IDLE    | waiting for mem_req; latches MAR/MDR_out/mem_we
// ACCESS  | SRAM strobes active for WAIT_CYCLES cycles
// HOLD    | write only: WE released, CE and data held one cycle
// DONE    | strobes idle, R pulsed
// RELEASE | waiting for mem_req to drop
module slc3_mem_sequencer
  import slc3_mem_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT,
  parameter int          ADDR_W      = 20
) (
  input  logic                Clk,
  input  logic                Reset,
  slc3_mem_sequencer_if.slave bus,
  input  logic [15:0]         S,
  output logic [15:0]         hex_data,
  output logic                CE,
  output logic                UB,
  output logic                LB,
  output logic                OE,
  output logic                WE,
  output logic [ADDR_W-1:0]   ADDR,
  inout  wire  [15:0]         Data
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [15:0]       mar_q, mar_nxt;
  logic [15:0]       mdr_q, mdr_nxt;
  logic              we_q, we_nxt;
  logic [15:0]       rd_q, rd_nxt;
  logic [15:0]       hex_nxt;
  logic [15:0]       data_in;
  logic              r_q, r_nxt;
  logic              drv_q, drv_nxt;
  logic              ce_nxt, oe_nxt, wen_nxt;
  logic [ADDR_W-1:0] addr_nxt;

  slc3_data_tristate u_tri (
    .drive_en (drv_q),
    .out_data (mdr_q),
    .in_data  (data_in),
    .Data     (Data)
  );

  assign bus.R       = r_q;
  assign bus.rd_data = rd_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mar_nxt   = mar_q;
    mdr_nxt   = mdr_q;
    we_nxt    = we_q;
    rd_nxt    = rd_q;
    hex_nxt   = hex_data;

    unique case (state)
      IDLE: begin
        if (bus.mem_req) begin
          mar_nxt = bus.MAR;
          mdr_nxt = bus.MDR_out;
          we_nxt  = bus.mem_we;
          cnt_nxt = CNT_LOAD;
          if (bus.MAR == IO_ADDR) begin
            state_nxt = DONE;
            if (bus.mem_we) hex_nxt = bus.MDR_out;
            else            rd_nxt  = S;
          end else begin
            state_nxt = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          if (we_q) begin
            state_nxt = HOLD;
          end else begin
            rd_nxt    = data_in;
            state_nxt = DONE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      HOLD:    state_nxt = DONE;
      DONE:    state_nxt = RELEASE;
      RELEASE: if (!bus.mem_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Pins are registered from the state being entered so they change on the same edge as the state.
    ce_nxt   = 1'b1;
    oe_nxt   = 1'b1;
    wen_nxt  = 1'b1;
    drv_nxt  = 1'b0;
    addr_nxt = ADDR;
    r_nxt    = (state_nxt == DONE);
    unique case (state_nxt)
      ACCESS: begin
        ce_nxt   = 1'b0;
        addr_nxt = ADDR_W'(mar_nxt);
        if (we_nxt) begin
          wen_nxt = 1'b0;
          drv_nxt = 1'b1;
        end else begin
          oe_nxt = 1'b0;
        end
      end
      HOLD: begin
        ce_nxt  = 1'b0;
        drv_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      mar_q    <= '0;
      mdr_q    <= '0;
      we_q     <= 1'b0;
      rd_q     <= '0;
      hex_data <= '0;
      r_q      <= 1'b0;
      drv_q    <= 1'b0;
      CE       <= 1'b1;
      UB       <= 1'b1;
      LB       <= 1'b1;
      OE       <= 1'b1;
      WE       <= 1'b1;
      ADDR     <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      mar_q    <= mar_nxt;
      mdr_q    <= mdr_nxt;
      we_q     <= we_nxt;
      rd_q     <= rd_nxt;
      hex_data <= hex_nxt;
      r_q      <= r_nxt;
      drv_q    <= drv_nxt;
      CE       <= ce_nxt;
      UB       <= ce_nxt;
      LB       <= ce_nxt;
      OE       <= oe_nxt;
      WE       <= wen_nxt;
      ADDR     <= addr_nxt;
    end
  end

endmodule

// File: tb/tb_slc3_mem_sequencer.sv
// Self-checking bench: SRAM device model plus a per-cycle expected-pin timeline built from access rules.
module tb_slc3_mem_sequencer;
  import slc3_mem_pkg::*;

  localparam int W    = 2;
  localparam int NCYC = 8192;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  slc3_mem_sequencer_if bus ();
  logic [15:0] S;
  logic [15:0] hex_data;
  logic        CE, UB, LB, OE, WE;
  logic [19:0] ADDR;
  wire  [15:0] Data;

  slc3_mem_sequencer #(.WAIT_CYCLES(W)) dut (
    .Clk      (clk),
    .Reset    (rst_n),
    .bus      (bus),
    .S        (S),
    .hex_data (hex_data),
    .CE       (CE),
    .UB       (UB),
    .LB       (LB),
    .OE       (OE),
    .WE       (WE),
    .ADDR     (ADDR),
    .Data     (Data)
  );

  // asynchronous SRAM: drives the bus while selected and output-enabled
  logic [15:0] sram    [65536];
  logic [15:0] ref_mem [65536];
  assign Data = (!CE && !OE) ? sram[ADDR[15:0]] : 16'hzzzz;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected pin timeline, indexed by the cycle following posedge number cyc
  logic        e_ce  [NCYC];
  logic        e_oe  [NCYC];
  logic        e_we  [NCYC];
  logic        e_drv [NCYC];
  logic        e_r   [NCYC];
  logic [15:0] e_addr[NCYC];
  logic [15:0] e_data[NCYC];
  logic [15:0] e_rd  [NCYC];
  logic [15:0] e_hex [NCYC];

  int   checks = 0;
  int   errors = 0;
  logic chk_en = 1'b0;
  int   r_cnt = 0, r_cyc = 0, oe_low = 0, we_low = 0, ce_low = 0, drv_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic fill_rd(input int from, input logic [15:0] v);
    for (int c = from; c < NCYC; c++) e_rd[c] = v;
  endtask

  task automatic fill_hex(input int from, input logic [15:0] v);
    for (int c = from; c < NCYC; c++) e_hex[c] = v;
  endtask

  // Access rules: I/O completes in the request cycle; SRAM holds strobes W cycles, writes add a hold cycle.
  task automatic sched(input logic we, input logic [15:0] mar, input logic [15:0] mdr,
                       input logic [15:0] sw, input int n, output int d);
    if (mar == IO_ADDR_DEFAULT) begin
      d = n;
      if (we) fill_hex(n, mdr);
      else    fill_rd(n, sw);
    end else begin
      for (int k = 0; k < W; k++) begin
        e_ce[n+k]   = 1'b0;
        e_addr[n+k] = mar;
        if (we) begin
          e_we[n+k]   = 1'b0;
          e_drv[n+k]  = 1'b1;
          e_data[n+k] = mdr;
        end else begin
          e_oe[n+k] = 1'b0;
        end
      end
      if (we) begin
        e_ce[n+W]   = 1'b0;
        e_addr[n+W] = mar;
        e_drv[n+W]  = 1'b1;
        e_data[n+W] = mdr;
        d = n + W + 1;
        ref_mem[mar] = mdr;
      end else begin
        d = n + W;
        fill_rd(d, ref_mem[mar]);
      end
    end
    e_r[d] = 1'b1;
  endtask

  task automatic compare_loop();
    int c;
    forever begin
      @(negedge clk);
      c = cyc;
      if (rst_n) begin
        if (!CE && !WE) sram[ADDR[15:0]] = Data;
        if (bus.R) begin r_cnt++; r_cyc = c; end
        if (!OE) oe_low++;
        if (!WE) we_low++;
        if (!CE) ce_low++;
        if (dut.drv_q) drv_cnt++;
      end
      if (chk_en && rst_n && c < NCYC) begin
        chk("CE", CE, e_ce[c]);
        chk("UB", UB, e_ce[c]);
        chk("LB", LB, e_ce[c]);
        chk("OE", OE, e_oe[c]);
        chk("WE", WE, e_we[c]);
        chk("drive", dut.drv_q, e_drv[c]);
        chk("R", bus.R, e_r[c]);
        chk("rd_data", bus.rd_data, e_rd[c]);
        chk("hex_data", hex_data, e_hex[c]);
        if (!e_ce[c]) chk("ADDR", ADDR, {4'h0, e_addr[c]});
        if (e_drv[c]) chk("Data", Data, e_data[c]);
        checks++;
        if (!OE && dut.drv_q) begin
          errors++;
          $display("FAIL oe_drive_overlap at cycle %0d: got OE=0 with drive=1 expected never", c);
        end
      end
    end
  endtask

  task automatic do_txn(input logic we, input logic [15:0] mar, input logic [15:0] mdr,
                        input logic [15:0] sw, input int hold, input bit drop,
                        input bit scramble, output int n);
    int d;
    @(posedge clk); #1;
    bus.MAR     = mar;
    bus.MDR_out = mdr;
    bus.mem_we  = we;
    S           = sw;
    bus.mem_req = 1'b1;
    n = cyc + 1;
    sched(we, mar, mdr, sw, n, d);
    while (cyc < d) begin
      @(posedge clk); #1;
      if (drop && cyc == n) bus.mem_req = 1'b0;
      if (scramble && cyc >= n) begin
        bus.MAR     = 16'($urandom);
        bus.MDR_out = 16'($urandom);
        bus.mem_we  = 1'($urandom);
        S           = 16'($urandom);
      end
    end
    repeat (hold) begin @(posedge clk); #1; end
    bus.mem_req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    int n, r0, oe0, we0, ce0, drv0;
    logic [15:0] v;
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    bus.MAR     = '0;
    bus.MDR_out = '0;
    S           = '0;
    for (int c = 0; c < NCYC; c++) begin
      e_ce[c] = 1'b1; e_oe[c] = 1'b1; e_we[c] = 1'b1; e_drv[c] = 1'b0; e_r[c] = 1'b0;
      e_addr[c] = '0; e_data[c] = '0; e_rd[c] = '0; e_hex[c] = '0;
    end
    for (int i = 0; i < 65536; i++) begin
      v = 16'($urandom);
      sram[i] = v;
      ref_mem[i] = v;
    end
    sram[3] = 16'h1234;
    ref_mem[3] = 16'h1234;
    fork compare_loop(); join_none

    repeat (3) @(posedge clk); #1;
    chk("reset_CE", CE, 1); chk("reset_OE", OE, 1); chk("reset_WE", WE, 1);
    chk("reset_UB", UB, 1); chk("reset_LB", LB, 1);
    chk("reset_R", bus.R, 0); chk("reset_drive", dut.drv_q, 0);
    chk("reset_ADDR", ADDR, 0); chk("reset_rd", bus.rd_data, 0); chk("reset_hex", hex_data, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // I/O write then I/O read
    ce0 = ce_low; r0 = r_cnt;
    do_txn(1'b1, 16'hFFFF, 16'h00A5, 16'h0000, 0, 0, 0, n);
    chk("io_wr_hex", hex_data, 16'h00A5);
    chk("io_wr_latency", r_cyc - n, 0);
    do_txn(1'b0, 16'hFFFF, 16'h7777, 16'h0003, 0, 0, 0, n);
    chk("io_rd_data", bus.rd_data, 16'h0003);
    chk("io_no_strobe", ce_low - ce0, 0);
    chk("io_r_pulses", r_cnt - r0, 2);

    // SRAM read: 2 OE cycles, R seen by controller 3 edges after request edge
    oe0 = oe_low; ce0 = ce_low; drv0 = drv_cnt; r0 = r_cnt;
    do_txn(1'b0, 16'h0003, 16'h0000, 16'h0000, 0, 0, 0, n);
    chk("rd_data_1234", bus.rd_data, 16'h1234);
    chk("rd_oe_cycles", oe_low - oe0, 2);
    chk("rd_ce_cycles", ce_low - ce0, 2);
    chk("rd_no_drive", drv_cnt - drv0, 0);
    chk("rd_latency", r_cyc - n + 1, 3);
    chk("rd_r_pulses", r_cnt - r0, 1);

    // SRAM write: 2 WE cycles + hold, R 4 edges after request edge
    we0 = we_low; drv0 = drv_cnt;
    do_txn(1'b1, 16'h0010, 16'hBEEF, 16'h0000, 0, 0, 0, n);
    chk("wr_we_cycles", we_low - we0, 2);
    chk("wr_drive_cycles", drv_cnt - drv0, 3);
    chk("wr_latency", r_cyc - n + 1, 4);
    chk("wr_sram_word", sram[16], 16'hBEEF);

    // request held 10 cycles past R, then dropped mid-access
    r0 = r_cnt; ce0 = ce_low;
    do_txn(1'b0, 16'h0010, 16'h0000, 16'h0000, 10, 0, 0, n);
    chk("held_r_pulses", r_cnt - r0, 1);
    chk("held_ce_cycles", ce_low - ce0, 2);
    chk("held_rd", bus.rd_data, 16'hBEEF);
    r0 = r_cnt;
    do_txn(1'b1, 16'h0020, 16'h5A5A, 16'h0000, 0, 1, 0, n);
    chk("drop_r_pulses", r_cnt - r0, 1);

    // inputs scrambled during the access
    do_txn(1'b1, 16'h0030, 16'hC0DE, 16'h0000, 1, 0, 1, n);
    do_txn(1'b0, 16'h0030, 16'h0000, 16'h0000, 1, 0, 1, n);
    chk("scramble_rd", bus.rd_data, 16'hC0DE);

    // reset asserted in the middle of a write
    @(posedge clk); #1;
    bus.MAR = 16'h0100; bus.MDR_out = 16'h1357; bus.mem_we = 1'b1; bus.mem_req = 1'b1;
    n = cyc + 1;
    begin
      int d;
      sched(1'b1, 16'h0100, 16'h1357, 16'h0000, n, d);
    end
    @(posedge clk); #3;
    chk("pre_rst_WE", WE, 0);
    rst_n = 1'b0; chk_en = 1'b0; bus.mem_req = 1'b0;
    #1;
    chk("mid_rst_WE", WE, 1); chk("mid_rst_CE", CE, 1); chk("mid_rst_OE", OE, 1);
    chk("mid_rst_drive", dut.drv_q, 0); chk("mid_rst_R", bus.R, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_hex", hex_data, 0);
    chk("post_rst_rd", bus.rd_data, 0);
    chk("post_rst_idle", dut.state == IDLE, 1);
    fill_rd(cyc, 16'h0000);
    fill_hex(cyc, 16'h0000);
    chk_en = 1'b1;

    for (int i = 0; i < 150; i++) begin
      logic        we;
      logic [15:0] mar;
      we  = 1'($urandom_range(0, 1));
      mar = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom_range(0, 255));
      do_txn(we, mar, 16'($urandom), 16'($urandom), $urandom_range(0, 3),
             ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), n);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
